seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan controller for the 4-digit 7-segment display. Sequences digit multiplexing and inserts
//  ghost-suppression dead time between digits. Snapshots hexs/points/LEs once per frame so
//  mid-frame updates from the number source never tear. Decodes nibbles to active-low segments.
//  Sits between the number source (buttons/switches) and the AN/SEGMENT board pins.
// PARAMETERS
//  DIV_W    17  prescaler width; each digit slot lasts exactly 2^DIV_W clk cycles
//  DEAD_CYC 4   all-off cycles between slots; 0 = no dead time (DEAD state skipped)
//  BLINK_W  25  blink counter width (used only with SCAN_BLINK_EN)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  hexs         in   16  four hex digits; digit i = hexs[4i+3:4i]
//  points       in   4   1 = light decimal point of digit i
//  LEs          in   4   1 = blank digit i for its whole slot
//  blink        in   4   (SCAN_BLINK_EN only) 1 = digit i blinks
//  AN           out  4   digit enables, active-low, one-hot-low or all 1
//  SEGMENT      out  8   {dp,g,f,e,d,c,b,a}, active-low
//  digit_sel    out  2   index of digit currently in SHOW
//  frame_start  out  1   1-cycle pulse when shadow registers load
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset (next edge): AN=4'hF, SEGMENT=8'hFF,
//    digit_sel=0, frame_start=0, state=LOAD, idx=0, prescaler=0, shadows hex=0/pt=0/LE=4'hF.
//  - FSM: LOAD -> SHOW -> DEAD -> SHOW ... ; when idx==3, leaving SHOW/DEAD goes to LOAD.
//    LOAD (1 cycle): copy hexs/points/LEs(/blink) into shadows, frame_start=1, idx=0,
//      prescaler=0, AN=F, SEGMENT=FF; -> SHOW.
//    SHOW: drive digit idx from shadows; prescaler +1 per cycle; at count 2^DIV_W-1 -> DEAD
//      (or, if DEAD_CYC==0, advance directly: idx+1 and restart prescaler, or LOAD if idx==3).
//    DEAD: AN=F, SEGMENT=FF for exactly DEAD_CYC cycles; then idx+1 -> SHOW (prescaler=0),
//      or LOAD if idx==3. idx wraps 3->0 only via LOAD.
//  - Frame period = 4*(2^DIV_W + DEAD_CYC) + 1 cycles; independent of input values.
//  - AN, SEGMENT, digit_sel, frame_start are registered: pins reflect the state one cycle later.
//  - In SHOW, idx=i: AN = ~(4'b1 << i); SEGMENT[6:0] = active-low decode of shadow nibble i
//    (0-F, standard hex glyphs, b/d lowercase); SEGMENT[7] = ~shadow_pt[i].
//  - shadow_LE[i]=1: AN=F and SEGMENT=FF for whole slot i; slot length unchanged.
//  - Inputs change anywhere in a frame: no effect until the next LOAD.
//  - rst asserted mid-slot: all state returns to reset values on that edge; scan restarts via LOAD.
// CONFIGURATION
//  SCAN_BLINK_EN defined: port blink[3:0] exists, shadowed in LOAD; free-running BLINK_W-bit
//    counter (reset 0); slot i is blanked like LE when shadow_blink[i]=1 and counter MSB=1.
//  SCAN_BLINK_EN undefined: no blink port, no blink counter; only LEs blanks.
// TESTING  (DIV_W=2, DEAD_CYC=1, BLINK_W=4 unless stated)
//  1 rst=1 3 cycles -> AN=F, SEGMENT=FF, frame_start=0; release -> frame_start pulses once,
//    then AN: 1110 x4, 1111 x1, 1101 x4, 1111, 1011 x4, 1111, 0111 x4, 1111, 1111(LOAD); period 21.
//  2 hexs=16'h1234, points=0, LEs=0 -> slot0 SEGMENT=8'h99 ('4'), slot3 SEGMENT=8'hF9 ('1').
//  3 hexs 16'h1234->16'hABCD during slot1 -> slots 1-3 still show 3,2,1; next frame shows D,C,B,A.
//  4 LEs=4'b0100 -> slot2 AN=1111/SEGMENT=FF all 4 cycles; slots 0,1,3 and period unchanged;
//    points=4'b0001 -> SEGMENT[7]=0 only during slot0.
//  5 DEAD_CYC=0 -> no all-off cycles except LOAD; period 17; rst mid-slot2 -> next cycle reset values.
//  6 SCAN_BLINK_EN, blink=4'b0001 -> slot0 lit while counter[3]=0, blank while counter[3]=1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: per-frame input snapshot, dead time between digits, hex decode.
// Optional per-digit blinking is enabled by defining SCAN_BLINK_EN.
module seg_scan_ctrl #(
    parameter int DIV_W    = 17,
    parameter int DEAD_CYC = 4,
    parameter int BLINK_W  = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
`ifdef SCAN_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic [1:0]  digit_sel,
    output logic        frame_start
);
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DW-1:0]    DEAD_LAST = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [DIV_W-1:0] PRE_LAST  = '1;

    typedef enum logic [1:0] {LOAD, SHOW, DEAD} state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [DIV_W-1:0] presc;
    logic [DW-1:0]    dcnt;
    logic [15:0]      sh_hex;
    logic [3:0]       sh_pt;
    logic [3:0]       sh_le;
    logic             blank;
    logic [3:0]       nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign nib = sh_hex[{idx, 2'b00} +: 4];

`ifdef SCAN_BLINK_EN
    logic [3:0]         sh_blink;
    logic [BLINK_W-1:0] bcnt;

    always_ff @(posedge clk) begin
        if (rst) bcnt <= '0;
        else     bcnt <= bcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                 sh_blink <= '0;
        else if (state == LOAD)  sh_blink <= blink;
    end

    assign blank = sh_le[idx] | (sh_blink[idx] & bcnt[BLINK_W-1]);
`else
    assign blank = sh_le[idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            idx         <= '0;
            presc       <= '0;
            dcnt        <= '0;
            sh_hex      <= '0;
            sh_pt       <= '0;
            sh_le       <= 4'hF;
            AN          <= 4'hF;
            SEGMENT     <= 8'hFF;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    sh_hex      <= hexs;
                    sh_pt       <= points;
                    sh_le       <= LEs;
                    frame_start <= 1'b1;
                    idx         <= '0;
                    presc       <= '0;
                    AN          <= 4'hF;
                    SEGMENT     <= 8'hFF;
                    state       <= SHOW;
                end
                SHOW: begin
                    frame_start <= 1'b0;
                    digit_sel   <= idx;
                    if (blank) begin
                        AN      <= 4'hF;
                        SEGMENT <= 8'hFF;
                    end else begin
                        AN      <= ~(4'b0001 << idx);
                        SEGMENT <= {~sh_pt[idx], hex7(nib)};
                    end
                    presc <= presc + 1'b1;
                    if (presc == PRE_LAST) begin
                        presc <= '0;
                        // With no dead time the slot hands straight over to the next digit.
                        if (DEAD_CYC == 0) begin
                            if (idx == 2'd3) state <= LOAD;
                            else             idx   <= idx + 2'd1;
                        end else begin
                            dcnt  <= '0;
                            state <= DEAD;
                        end
                    end
                end
                DEAD: begin
                    frame_start <= 1'b0;
                    AN          <= 4'hF;
                    SEGMENT     <= 8'hFF;
                    if (dcnt == DEAD_LAST) begin
                        presc <= '0;
                        if (idx == 2'd3) begin
                            state <= LOAD;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= SHOW;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
